// File: rtl/dct_pkg.sv
// dct_pkg: shared constants and stored-word type for the 4-point DCT output path.
package dct_pkg;
  localparam int DCT_N = 4;
  localparam int COEF_W = 16;
  localparam int DEF_FRAC_BITS = 4;
  localparam int DEF_OUT_W = 12;
  typedef struct packed {
    logic sat;
    logic signed [DEF_OUT_W-1:0] data;
  } coef_word_t;
endpackage

// File: rtl/dct_round_sat.sv
// dct_round_sat: round a signed fixed-point coefficient to integer (half toward +inf) and saturate.
module dct_round_sat #(
  parameter int DATA_W = 16,
  parameter int FRAC_BITS = 4,
  parameter int OUT_W = 12
) (
  input  logic signed [DATA_W-1:0] x,
  output logic signed [OUT_W-1:0]  y,
  output logic                     sat
);
  localparam logic signed [DATA_W:0] HALF = (DATA_W+1)'(1 << (FRAC_BITS-1));
  localparam logic signed [DATA_W:0] MAX = (DATA_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [DATA_W:0] MIN = (DATA_W+1)'(-(1 << (OUT_W-1)));
  logic signed [DATA_W:0] t, s;
  logic hi, lo;
  // One guard bit keeps the rounding offset from overflowing near +full-scale
  assign t = {x[DATA_W-1], x} + HALF;
  assign s = t >>> FRAC_BITS;
  assign hi = s > MAX;
  assign lo = s < MIN;
  assign sat = hi || lo;
  assign y = hi ? MAX[OUT_W-1:0] : lo ? MIN[OUT_W-1:0] : s[OUT_W-1:0];
endmodule

// File: rtl/dct4_coef_serializer.sv
// dct4_coef_serializer: rescales 4-coefficient DCT blocks, ping-pong buffers two of them,
// and streams the coefficients out one per handshake in index order.
module dct4_coef_serializer
  import dct_pkg::*;
#(
  parameter int DATA_W = COEF_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                     i_clk,
  input  logic                     i_clr_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_data0,
  input  logic signed [DATA_W-1:0] i_data1,
  input  logic signed [DATA_W-1:0] i_data2,
  input  logic signed [DATA_W-1:0] i_data3,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [OUT_W-1:0]  o_data,
  output logic [1:0]               o_index,
  output logic                     o_last,
  output logic                     o_sat
);
  logic [1:0] count, idx;
  logic wr_ptr, rd_ptr;
  logic accept, xfer, release_blk;
  logic signed [DATA_W-1:0] din [DCT_N];
  logic signed [OUT_W-1:0] y_in [DCT_N];
  logic sat_in [DCT_N];
  coef_word_t mem [2][DCT_N];
  coef_word_t cur;
  always_comb begin
    din[0] = i_data0;
    din[1] = i_data1;
    din[2] = i_data2;
    din[3] = i_data3;
  end
  for (genvar g = 0; g < DCT_N; g++) begin : g_rs
    dct_round_sat #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W)) u_rs (
      .x(din[g]),
      .y(y_in[g]),
      .sat(sat_in[g])
    );
  end
  // Handshake flags come from registered count only, so no input-to-output paths
  assign o_ready = count != 2'd2;
  assign o_valid = count != 2'd0;
  assign accept = i_valid && o_ready;
  assign xfer = o_valid && i_ready;
  assign release_blk = xfer && idx == 2'd3;
  assign cur = mem[rd_ptr][idx];
  // The store has no reset; masking with o_valid keeps idle outputs at zero
  assign o_data = o_valid ? cur.data : '0;
  assign o_sat = o_valid && cur.sat;
  assign o_index = idx;
  assign o_last = o_valid && idx == 2'd3;
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      count <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx <= 2'd0;
    end else begin
      count <= count + {1'b0, accept} - {1'b0, release_blk};
      wr_ptr <= wr_ptr ^ accept;
      rd_ptr <= rd_ptr ^ release_blk;
      if (xfer) idx <= idx + 2'd1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (accept) for (int k = 0; k < DCT_N; k++) mem[wr_ptr][k] <= '{sat: sat_in[k], data: y_in[k]};
  end
endmodule

// File: tb/tb_dct4_coef_serializer.sv
// tb_dct4_coef_serializer: scoreboard bench for the DCT coefficient serializer.
module tb_dct4_coef_serializer;
  logic clk = 1'b0;
  logic i_clr_n, i_valid, i_ready;
  logic o_ready, o_valid, o_last, o_sat;
  logic signed [15:0] i_data0, i_data1, i_data2, i_data3;
  logic signed [11:0] o_data;
  logic [1:0] o_index;
  typedef struct {
    int data;
    int idx;
    bit last;
    bit sat;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int seen[$];
  int checks = 0, failures = 0;
  int n0, found;
  int hd, hi, hv;
  int pat[6] = '{1, 0, 0, 1, 1, 1};
  dct4_coef_serializer dut (
    .i_clk(clk), .i_clr_n(i_clr_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2), .i_data3(i_data3),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_index(o_index),
    .o_last(o_last), .o_sat(o_sat)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  function automatic exp_t model(input int x, input int i);
    exp_t r;
    int y;
    y = (x + 8) >>> 4;
    r.sat = 1'b0;
    if (y > 2047) begin
      y = 2047;
      r.sat = 1'b1;
    end else if (y < -2048) begin
      y = -2048;
      r.sat = 1'b1;
    end
    r.data = y;
    r.idx = i;
    r.last = (i == 3);
    return r;
  endfunction
  always @(negedge clk) begin
    if (!i_clr_n) sb.delete();
    else begin
      if (o_valid && i_ready) begin
        if (sb.size() == 0) check("spurious_sample", 1, 0);
        else begin
          e = sb.pop_front();
          check("data", o_data, e.data);
          check("index", o_index, e.idx);
          check("last", o_last, e.last);
          check("sat", o_sat, e.sat);
        end
        seen.push_back(o_data);
      end
      if (i_valid && o_ready) begin
        sb.push_back(model(i_data0, 0));
        sb.push_back(model(i_data1, 1));
        sb.push_back(model(i_data2, 2));
        sb.push_back(model(i_data3, 3));
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int a, input int b, input int c, input int d);
    bit ok = 1'b0;
    i_data0 = 16'(a);
    i_data1 = 16'(b);
    i_data2 = 16'(c);
    i_data3 = 16'(d);
    i_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = o_ready;
      tick();
    end
    i_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask
  task automatic drain;
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = sb.size() == 0 && !o_valid;
    end
    if (!done) check("drain_timeout", 0, 1);
    tick();
  endtask
  task automatic check_tail(input string tag, input int a, input int b, input int c, input int d);
    int n = seen.size();
    check({tag, "_count"}, int'(n >= 4), 1);
    if (n >= 4) begin
      check({tag, "_0"}, seen[n-4], a);
      check({tag, "_1"}, seen[n-3], b);
      check({tag, "_2"}, seen[n-2], c);
      check({tag, "_3"}, seen[n-1], d);
    end
  endtask
  initial begin
    i_clr_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data0 = '0;
    i_data1 = '0;
    i_data2 = '0;
    i_data3 = '0;
    repeat (2) tick();
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_data", o_data, 0);
    check("rst_index", o_index, 0);
    check("rst_last", o_last, 0);
    check("rst_sat", o_sat, 0);
    i_clr_n = 1'b1;
    tick();
    check("rel_ready", o_ready, 1);
    check("rel_valid", o_valid, 0);
    i_ready = 1'b1;
    send(16, -24, 24, 32760);
    check("latency_valid", o_valid, 1);
    check("latency_data", o_data, 1);
    drain();
    check_tail("round", 1, -1, 2, 2047);
    send(8, -8, 7, -9);
    drain();
    check_tail("edge", 1, 0, 0, -1);
    send(-32768, 0, 0, 0);
    drain();
    check_tail("negfs", -2048, 0, 0, 0);
    i_ready = 1'b0;
    n0 = seen.size();
    send(1000, -1000, 5000, -5000);
    send(32767, -32767, 123, -123);
    check("full_ready", o_ready, 0);
    fork
      send(7, 23, 39, -100);
      begin
        repeat (3) tick();
        check("full_hold", o_ready, 0);
        check("full_valid", o_valid, 1);
        i_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", seen.size() - n0, 12);
    i_ready = 1'b0;
    n0 = seen.size();
    send(100, 200, 300, 400);
    for (int p = 0; p < 6; p++) begin
      i_ready = pat[p][0];
      @(negedge clk);
      hd = o_data;
      hi = o_index;
      hv = o_valid;
      tick();
      if (pat[p] == 0 && hv != 0) begin
        check("stall_data", o_data, hd);
        check("stall_index", o_index, hi);
      end
    end
    i_ready = 1'b1;
    drain();
    check("stall_count", seen.size() - n0, 4);
    check_tail("stall", 6, 13, 19, 25);
    send(160, 320, 480, 640);
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      if (o_index == 2'd3) found = 1;
      else tick();
    end
    check("idx3_reached", found, 1);
    send(-160, -320, -480, -640);
    check("conc_valid", o_valid, 1);
    check("conc_index", o_index, 0);
    check("conc_ready", o_ready, 1);
    check("conc_data", o_data, -10);
    drain();
    check_tail("conc", -10, -20, -30, -40);
    send(48, 64, 80, 96);
    n0 = seen.size();
    for (int n = 0; n < 20 && seen.size() < n0 + 2; n++) tick();
    check("mid_two", seen.size() - n0, 2);
    i_clr_n = 1'b0;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_ready", o_ready, 1);
    repeat (2) tick();
    i_clr_n = 1'b1;
    tick();
    check("post_rst_ready", o_ready, 1);
    n0 = seen.size();
    repeat (8) tick();
    check("no_stale", seen.size() - n0, 0);
    check("post_rst_valid", o_valid, 0);
    send(-16, -32, -48, -64);
    drain();
    check_tail("post_rst", -1, -2, -3, -4);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
